// File: rtl/parity_combination_index_if.sv
// -----------------------------------------------------------------------------
// parity_combination_index_if
// Query/response bundle of the parity combination index.
//   query_valid/query_ready   : request handshake (accept on both high)
//   query_kind                : 0 = first-for-parity, 1 = next-after-combination
//   query_parity              : parity looked up by kind 0
//   query_combination         : previous combination for kind 1
//   resp_valid                : one-cycle pulse per accepted query
//   resp_found                : response carries a combination
//   resp_combination          : list head (kind 0) or successor (kind 1)
//   resp_count                : list length (kind 0), 0 for kind 1
//   resp_min_combination      : minimum-weight list member (kind 0)
// master = query issuer (solver), slave = the index.
// -----------------------------------------------------------------------------
interface parity_combination_index_if #(
  parameter int LIGHT_COUNT      = 10,
  parameter int MAX_BUTTON_COUNT = 13,
  parameter int COUNT_WIDTH      = MAX_BUTTON_COUNT + 1
);
  logic                        query_valid;
  logic                        query_ready;
  logic                        query_kind;
  logic [LIGHT_COUNT-1:0]      query_parity;
  logic [MAX_BUTTON_COUNT:0]   query_combination;
  logic                        resp_valid;
  logic                        resp_found;
  logic [MAX_BUTTON_COUNT:0]   resp_combination;
  logic [COUNT_WIDTH-1:0]      resp_count;
  logic [MAX_BUTTON_COUNT:0]   resp_min_combination;

  modport master (
    output query_valid, query_kind, query_parity, query_combination,
    input  query_ready, resp_valid, resp_found, resp_combination,
           resp_count, resp_min_combination
  );

  modport slave (
    input  query_valid, query_kind, query_parity, query_combination,
    output query_ready, resp_valid, resp_found, resp_combination,
           resp_count, resp_min_combination
  );
endinterface

// File: rtl/parity_combination_index.sv
// -----------------------------------------------------------------------------
// parity_combination_index
// Enumerates every button combination c < N, computes its XOR parity over the
// button light masks and builds, per parity, an insertion-ordered linked list
// (head/tail/next), an element count and optionally the minimum-weight member.
// The finished table is walked through a valid/ready query port.
//
// Ports:
//   clk                      : system clock
//   reset                    : synchronous, active-high reset
//   build_start              : pulse, starts/restarts a build (any state)
//   flattened_buttons        : button b mask at [b*LIGHT_COUNT +: LIGHT_COUNT]
//   combination_upper_bound  : exclusive bound N, sampled at build_start
//   build_busy               : high while the build runs (2N+1 cycles)
//   table_ready              : idle with a valid table
//   qif                      : query/response bundle (slave side)
//
// Optional feature macro: PARITY_INDEX_MIN_WEIGHT_TRACK_EN
//   defined   : per-parity minimum-popcount member is tracked and returned
//   undefined : resp_min_combination is tied to 0
// -----------------------------------------------------------------------------
module parity_combination_index #(
  parameter int LIGHT_COUNT      = 10,
  parameter int MAX_BUTTON_COUNT = 13,
  parameter int COUNT_WIDTH      = MAX_BUTTON_COUNT + 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 build_start,
  input  logic [LIGHT_COUNT*MAX_BUTTON_COUNT-1:0] flattened_buttons,
  input  logic [MAX_BUTTON_COUNT:0]            combination_upper_bound,
  output logic                                 build_busy,
  output logic                                 table_ready,
  parity_combination_index_if.slave            qif
);

  localparam int CW           = MAX_BUTTON_COUNT + 1;
  localparam int PARITY_DEPTH = 1 << LIGHT_COUNT;
  localparam int COMB_DEPTH   = 1 << MAX_BUTTON_COUNT;
  localparam logic [CW-1:0] COMB_SPACE = CW'(COMB_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INS1 = 2'd1,
    INS2 = 2'd2
  } state_t;

  // XOR of the masks of every button selected in comb.
  function automatic logic [LIGHT_COUNT-1:0] parity_of(
    input logic [CW-1:0]                         comb,
    input logic [LIGHT_COUNT*MAX_BUTTON_COUNT-1:0] masks
  );
    logic [LIGHT_COUNT-1:0] acc;
    acc = '0;
    for (int b = 0; b < MAX_BUTTON_COUNT; b++) begin
      if (comb[b]) begin
        acc = acc ^ masks[b*LIGHT_COUNT +: LIGHT_COUNT];
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

`ifdef PARITY_INDEX_MIN_WEIGHT_TRACK_EN
  // Number of pressed buttons in a combination.
  function automatic logic [CW-1:0] weight_of(input logic [CW-1:0] v);
    logic [CW-1:0] w;
    w = '0;
    for (int i = 0; i < CW; i++) begin
      w = w + CW'(v[i]);
    end
    return w;
  endfunction
`endif

  // Table storage; contents are only trusted where created_r is set.
  logic [CW-1:0]          head_mem  [PARITY_DEPTH];
  logic [CW-1:0]          tail_mem  [PARITY_DEPTH];
  logic [COUNT_WIDTH-1:0] count_mem [PARITY_DEPTH];
  logic [CW:0]            next_mem  [COMB_DEPTH];
`ifdef PARITY_INDEX_MIN_WEIGHT_TRACK_EN
  logic [CW-1:0]          min_mem   [PARITY_DEPTH];
  logic [CW-1:0]          min_rd_r;
  logic [CW-1:0]          min_wr_s;
`endif

  logic [PARITY_DEPTH-1:0] created_r;

  state_t                 state_r;
  state_t                 state_s;
  logic [CW-1:0]          cur_r;
  logic [CW-1:0]          bound_r;
  logic [CW-1:0]          bound_s;
  logic [LIGHT_COUNT-1:0] cur_parity_s;
  logic [LIGHT_COUNT-1:0] p_r;
  logic                   created_l_r;
  logic [CW-1:0]          tail_rd_r;
  logic [COUNT_WIDTH-1:0] count_rd_r;
  logic                   build_busy_r;
  logic                   table_ready_r;
  logic                   store_s;
  logic                   accept_s;

  logic                   resp_valid_r;
  logic                   resp_found_r;
  logic [CW-1:0]          resp_comb_r;
  logic [COUNT_WIDTH-1:0] resp_count_r;
  logic [CW-1:0]          resp_min_r;

  assign cur_parity_s = parity_of(cur_r, flattened_buttons);
  assign store_s      = (state_r == INS1) && (cur_r < bound_r);
  assign accept_s     = qif.query_valid && table_ready_r && !build_start;

  // Bounds beyond the combination space are clamped to it.
  always_comb begin
    bound_s = combination_upper_bound;
    if (combination_upper_bound > COMB_SPACE) begin
      bound_s = COMB_SPACE;
    end else begin
      bound_s = combination_upper_bound;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; build_start restarts from any state.
  always_comb begin
    state_s = state_r;
    if (build_start) begin
      state_s = INS1;
    end else begin
      case (state_r)
        IDLE:    state_s = IDLE;
        INS1:    state_s = (cur_r >= bound_r) ? IDLE : INS2;
        INS2:    state_s = INS1;
        default: state_s = IDLE;
      endcase
    end
  end

  // Build datapath: enumeration counter, created flags and INS1 read latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_r         <= '0;
      bound_r       <= '0;
      created_r     <= '0;
      p_r           <= '0;
      created_l_r   <= 1'b0;
      tail_rd_r     <= '0;
      count_rd_r    <= '0;
      build_busy_r  <= 1'b0;
      table_ready_r <= 1'b0;
    end else begin
      build_busy_r <= (state_s != IDLE);
      if (build_start) begin
        cur_r         <= '0;
        bound_r       <= bound_s;
        created_r     <= '0;
        table_ready_r <= 1'b0;
      end else begin
        case (state_r)
          INS1: begin
            if (cur_r >= bound_r) begin
              table_ready_r <= 1'b1;
            end else begin
              p_r                     <= cur_parity_s;
              created_l_r             <= created_r[cur_parity_s];
              created_r[cur_parity_s] <= 1'b1;
              tail_rd_r               <= tail_mem[cur_parity_s];
              count_rd_r              <= count_mem[cur_parity_s];
            end
          end
          INS2:    cur_r <= cur_r + CW'(1);
          default: cur_r <= cur_r;
        endcase
      end
    end
  end

`ifdef PARITY_INDEX_MIN_WEIGHT_TRACK_EN
  // Min read in INS1 alongside tail/count.
  always_ff @(posedge clk) begin
    if (store_s) begin
      min_rd_r <= min_mem[cur_parity_s];
    end
  end

  // Strict less-than keeps the earlier (smaller) combination on ties.
  always_comb begin
    min_wr_s = min_rd_r;
    if (!created_l_r || (weight_of(cur_r) < weight_of(min_rd_r))) begin
      min_wr_s = cur_r;
    end else begin
      min_wr_s = min_rd_r;
    end
  end

  // Min array write.
  always_ff @(posedge clk) begin
    if (state_r == INS2) begin
      min_mem[p_r] <= min_wr_s;
    end
  end
`endif

  // Next array: cleared entry in INS1, link from the old tail in INS2.
  always_ff @(posedge clk) begin
    if (store_s) begin
      next_mem[cur_r[MAX_BUTTON_COUNT-1:0]] <= '0;
    end else if ((state_r == INS2) && created_l_r) begin
      next_mem[tail_rd_r[MAX_BUTTON_COUNT-1:0]] <= {1'b1, cur_r};
    end
  end

  // Head/tail/count writes in INS2.
  always_ff @(posedge clk) begin
    if (state_r == INS2) begin
      tail_mem[p_r]  <= cur_r;
      count_mem[p_r] <= created_l_r ? (count_rd_r + COUNT_WIDTH'(1)) : COUNT_WIDTH'(1);
      if (!created_l_r) begin
        head_mem[p_r] <= cur_r;
      end
    end
  end

  // Query response registers; reads are gated by created_r / bound.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_r <= 1'b0;
      resp_found_r <= 1'b0;
      resp_comb_r  <= '0;
      resp_count_r <= '0;
      resp_min_r   <= '0;
    end else if (build_start) begin
      resp_valid_r <= 1'b0;
    end else begin
      resp_valid_r <= accept_s;
      if (accept_s) begin
        if (!qif.query_kind) begin
          if (created_r[qif.query_parity]) begin
            resp_found_r <= 1'b1;
            resp_comb_r  <= head_mem[qif.query_parity];
            resp_count_r <= count_mem[qif.query_parity];
`ifdef PARITY_INDEX_MIN_WEIGHT_TRACK_EN
            resp_min_r   <= min_mem[qif.query_parity];
`else
            resp_min_r   <= '0;
`endif
          end else begin
            resp_found_r <= 1'b0;
            resp_comb_r  <= '0;
            resp_count_r <= '0;
            resp_min_r   <= '0;
          end
        end else begin
          resp_count_r <= '0;
          resp_min_r   <= '0;
          if ((qif.query_combination < bound_r) &&
              next_mem[qif.query_combination[MAX_BUTTON_COUNT-1:0]][CW]) begin
            resp_found_r <= 1'b1;
            resp_comb_r  <= next_mem[qif.query_combination[MAX_BUTTON_COUNT-1:0]][CW-1:0];
          end else begin
            resp_found_r <= 1'b0;
            resp_comb_r  <= '0;
          end
        end
      end
    end
  end

  assign build_busy               = build_busy_r;
  assign table_ready              = table_ready_r;
  assign qif.query_ready          = table_ready_r && !build_start;
  assign qif.resp_valid           = resp_valid_r;
  assign qif.resp_found           = resp_found_r;
  assign qif.resp_combination     = resp_comb_r;
  assign qif.resp_count           = resp_count_r;
  assign qif.resp_min_combination = resp_min_r;

endmodule

// File: tb/tb_parity_combination_index.sv
// -----------------------------------------------------------------------------
// tb_parity_combination_index
// Self-checking bench for parity_combination_index (LIGHT_COUNT=4,
// MAX_BUTTON_COUNT=3). Expected values come from fixed tables and from a
// list-free reference model that scans combinations directly.
// -----------------------------------------------------------------------------
module tb_parity_combination_index;
  localparam int L    = 4;
  localparam int M    = 3;
  localparam int CW   = M + 1;
  localparam int CNTW = M + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              build_start;
  logic [L*M-1:0]    flattened_buttons;
  logic [CW-1:0]     combination_upper_bound;
  logic              build_busy;
  logic              table_ready;

  parity_combination_index_if #(.LIGHT_COUNT(L), .MAX_BUTTON_COUNT(M), .COUNT_WIDTH(CNTW)) qif ();

  parity_combination_index #(.LIGHT_COUNT(L), .MAX_BUTTON_COUNT(M), .COUNT_WIDTH(CNTW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .build_start             (build_start),
    .flattened_buttons       (flattened_buttons),
    .combination_upper_bound (combination_upper_bound),
    .build_busy              (build_busy),
    .table_ready             (table_ready),
    .qif                     (qif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [L-1:0] masks [M];
  int model_n = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [L-1:0] m_parity(input int c);
    logic [L-1:0] a;
    a = '0;
    for (int b = 0; b < M; b++) if (((c >> b) & 1) == 1) a = a ^ masks[b];
    return a;
  endfunction

  function automatic int m_weight(input int c);
    int w;
    w = 0;
    for (int b = 0; b < CW; b++) w += (c >> b) & 1;
    return w;
  endfunction

  task automatic set_masks(input logic [L-1:0] m0, input logic [L-1:0] m1, input logic [L-1:0] m2);
    masks[0] = m0; masks[1] = m1; masks[2] = m2;
    flattened_buttons = {m2, m1, m0};
  endtask

  // Reference: scan all combinations below N in ascending order.
  task automatic model_query(input logic kind, input logic [L-1:0] p, input logic [CW-1:0] c,
                             output logic found, output logic [CW-1:0] comb,
                             output logic [CNTW-1:0] cnt, output logic [CW-1:0] mn);
    int n_found, bestw;
    found = 1'b0; comb = '0; cnt = '0; mn = '0;
    if (kind == 1'b0) begin
      n_found = 0; bestw = 100;
      for (int k = 0; k < model_n; k++) begin
        if (m_parity(k) == p) begin
          if (n_found == 0) comb = CW'(k);
          if (m_weight(k) < bestw) begin bestw = m_weight(k); mn = CW'(k); end
          n_found++;
        end
      end
      found = (n_found > 0);
      cnt   = CNTW'(n_found);
`ifndef PARITY_INDEX_MIN_WEIGHT_TRACK_EN
      mn = '0;
`endif
    end else if (int'(c) < model_n) begin
      for (int k = int'(c) + 1; k < model_n; k++) begin
        if (!found && (m_parity(k) == m_parity(int'(c)))) begin
          found = 1'b1; comb = CW'(k);
        end
      end
    end
  endtask

  // Pulse build_start and count build_busy cycles until table_ready.
  task automatic do_build(input int n, output int busy_cycles, output logic done);
    logic [31:0] nv;
    nv = n;
    combination_upper_bound = nv[CW-1:0];
    model_n = (n > (1 << M)) ? (1 << M) : n;
    build_start = 1'b1;
    tick;
    build_start = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 200 && !table_ready; k++) begin
      if (build_busy) busy_cycles++;
      tick;
    end
    done = table_ready;
  endtask

  // Issue one query and capture the response (no checking here).
  task automatic do_query(input logic kind, input logic [L-1:0] p, input logic [CW-1:0] c,
                          output logic ok, output logic found, output logic [CW-1:0] comb,
                          output logic [CNTW-1:0] cnt, output logic [CW-1:0] mn);
    qif.query_valid = 1'b1; qif.query_kind = kind;
    qif.query_parity = p; qif.query_combination = c;
    for (int k = 0; k < 20 && !qif.query_ready; k++) tick;
    ok = 1'b0;
    if (qif.query_ready) begin
      tick;
      ok = qif.resp_valid;
    end
    found = qif.resp_found; comb = qif.resp_combination;
    cnt = qif.resp_count; mn = qif.resp_min_combination;
    qif.query_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; build_start = 1'b0; qif.query_valid = 1'b0;
    qif.query_kind = 1'b0; qif.query_parity = '0; qif.query_combination = '0;
    combination_upper_bound = '0;
    set_masks(4'b0001, 4'b0011, 4'b0010);
    tick; tick;
    reset = 1'b0;
    tick;
    checks++;
    if (build_busy !== 1'b0 || table_ready !== 1'b0 || qif.query_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b ready=%b qready=%b, expected 0 0 0", build_busy, table_ready, qif.query_ready);
    end
    checks++;
    if (qif.resp_valid !== 1'b0 || qif.resp_found !== 1'b0 || qif.resp_combination !== 4'd0 ||
        qif.resp_count !== 4'd0 || qif.resp_min_combination !== 4'd0) begin
      errors++;
      $display("FAIL reset_resp: got v=%b f=%b c=%0d n=%0d m=%0d, expected all 0", qif.resp_valid,
               qif.resp_found, qif.resp_combination, qif.resp_count, qif.resp_min_combination);
    end
  endtask

  task automatic test_plan_build;
    int busy; logic done;
    logic       q_kind [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] q_par  [9] = '{4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd3, 4'd0, 4'd0, 4'd0};
    logic [3:0] q_comb [9] = '{4'd0, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2};
    logic       e_fnd  [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] e_comb [9] = '{4'd3, 4'd4, 4'd0, 4'd0, 4'd1, 4'd2, 4'd7, 4'd6, 4'd5};
    logic [3:0] e_cnt  [9] = '{4'd2, 4'd0, 4'd0, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0};
    logic [3:0] e_min  [9] = '{4'd4, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0};
    logic ok, f; logic [CW-1:0] c, mn, em; logic [CNTW-1:0] n;
    set_masks(4'b0001, 4'b0011, 4'b0010);
    do_build(8, busy, done);
    checks++;
    if (!done || busy != 17) begin
      errors++;
      $display("FAIL build8_time: got busy=%0d done=%b, expected 17 1", busy, done);
    end
    for (int i = 0; i < 9; i++) begin
      do_query(q_kind[i], q_par[i], q_comb[i], ok, f, c, n, mn);
`ifdef PARITY_INDEX_MIN_WEIGHT_TRACK_EN
      em = e_min[i];
`else
      em = 4'd0;
`endif
      checks++;
      if (ok !== 1'b1 || f !== e_fnd[i] || c !== e_comb[i] || n !== e_cnt[i] || mn !== em) begin
        errors++;
        $display("FAIL plan_query%0d: got v=%b f=%b c=%0d n=%0d m=%0d, expected 1 %b %0d %0d %0d",
                 i, ok, f, c, n, mn, e_fnd[i], e_comb[i], e_cnt[i], em);
      end
    end
  endtask

  task automatic test_small_and_restart;
    int busy; logic done; logic ok, f; logic [CW-1:0] c, mn; logic [CNTW-1:0] n;
    do_build(3, busy, done);
    checks++;
    if (!done || busy != 7) begin
      errors++;
      $display("FAIL build3_time: got busy=%0d done=%b, expected 7 1", busy, done);
    end
    do_query(1'b0, 4'b0010, 4'd0, ok, f, c, n, mn);
    checks++;
    if (ok !== 1'b1 || f !== 1'b0 || c !== 4'd0 || n !== 4'd0 || mn !== 4'd0) begin
      errors++;
      $display("FAIL small_empty_parity: got v=%b f=%b c=%0d n=%0d m=%0d, expected 1 0 0 0 0", ok, f, c, n, mn);
    end
    do_query(1'b1, 4'd0, 4'd5, ok, f, c, n, mn);
    checks++;
    if (ok !== 1'b1 || f !== 1'b0 || c !== 4'd0) begin
      errors++;
      $display("FAIL small_beyond_bound: got v=%b f=%b c=%0d, expected 1 0 0", ok, f, c);
    end
    // Restart on the second busy cycle.
    build_start = 1'b1; tick; build_start = 1'b0;
    tick;
    build_start = 1'b1; tick; build_start = 1'b0;
    busy = 0;
    for (int k = 0; k < 100 && !table_ready; k++) begin
      if (build_busy) busy++;
      tick;
    end
    checks++;
    if (!table_ready || busy != 7) begin
      errors++;
      $display("FAIL restart_time: got busy=%0d ready=%b, expected 7 1", busy, table_ready);
    end
    do_query(1'b0, 4'd0, 4'd0, ok, f, c, n, mn);
    checks++;
    if (ok !== 1'b1 || f !== 1'b1 || c !== 4'd0 || n !== 4'd1) begin
      errors++;
      $display("FAIL restart_query: got v=%b f=%b c=%0d n=%0d, expected 1 1 0 1", ok, f, c, n);
    end
    do_build(0, busy, done);
    checks++;
    if (!done || busy != 1) begin
      errors++;
      $display("FAIL build0_time: got busy=%0d done=%b, expected 1 1", busy, done);
    end
    do_query(1'b0, 4'd0, 4'd0, ok, f, c, n, mn);
    checks++;
    if (ok !== 1'b1 || f !== 1'b0 || n !== 4'd0) begin
      errors++;
      $display("FAIL build0_query: got v=%b f=%b n=%0d, expected 1 0 0", ok, f, n);
    end
  endtask

  task automatic test_reset_mid_build;
    logic ok, f; logic [CW-1:0] c, mn; logic [CNTW-1:0] n; int seen; int busy;
    logic ef; logic [CW-1:0] ec, em; logic [CNTW-1:0] en;
    set_masks(4'b0001, 4'b0011, 4'b0010);
    do_build(8, busy, ok);
    do_query(1'b0, 4'b0010, 4'd0, ok, f, c, n, mn);   // leave non-zero response
    combination_upper_bound = 4'd8;
    build_start = 1'b1; tick; build_start = 1'b0;     // now INS1
    tick;                                             // now INS2
    reset = 1'b1; tick; reset = 1'b0;
    checks++;
    if (build_busy !== 1'b0 || table_ready !== 1'b0 || qif.resp_valid !== 1'b0 ||
        qif.resp_found !== 1'b0 || qif.resp_combination !== 4'd0 || qif.resp_count !== 4'd0 ||
        qif.resp_min_combination !== 4'd0) begin
      errors++;
      $display("FAIL reset_ins2: got busy=%b ready=%b v=%b f=%b c=%0d n=%0d m=%0d, expected all 0",
               build_busy, table_ready, qif.resp_valid, qif.resp_found, qif.resp_combination,
               qif.resp_count, qif.resp_min_combination);
    end
    qif.query_valid = 1'b1; qif.query_kind = 1'b0; qif.query_parity = 4'b0010;
    seen = 0;
    for (int k = 0; k < 4; k++) begin tick; if (qif.resp_valid) seen++; end
    model_n = 8;
    build_start = 1'b1; tick; build_start = 1'b0;
    for (int k = 0; k < 100 && !table_ready; k++) begin
      if (qif.resp_valid) seen++;
      tick;
    end
    checks++;
    if (seen != 0 || !table_ready || qif.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL held_query_blocked: got early_resps=%0d ready=%b v=%b, expected 0 1 0",
               seen, table_ready, qif.resp_valid);
    end
    tick;
    model_query(1'b0, 4'b0010, 4'd0, ef, ec, en, em);
    checks++;
    if (qif.resp_valid !== 1'b1 || qif.resp_found !== ef || qif.resp_combination !== ec ||
        qif.resp_count !== en || qif.resp_min_combination !== em) begin
      errors++;
      $display("FAIL held_query_accept: got v=%b f=%b c=%0d n=%0d m=%0d, expected 1 %b %0d %0d %0d",
               qif.resp_valid, qif.resp_found, qif.resp_combination, qif.resp_count,
               qif.resp_min_combination, ef, ec, en, em);
    end
    qif.query_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    int busy; logic done; logic ef; logic [CW-1:0] ec, em; logic [CNTW-1:0] en;
    logic [L-1:0] p; logic [CW-1:0] qc; logic kd;
    set_masks(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    do_build(8, busy, done);
    qif.query_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      kd = 1'($urandom_range(0, 1));
      p  = 4'($urandom_range(0, 15));
      qc = 4'($urandom_range(0, 15));
      qif.query_kind = kd; qif.query_parity = p; qif.query_combination = qc;
      tick;
      model_query(kd, p, qc, ef, ec, en, em);
      checks++;
      if (qif.resp_valid !== 1'b1 || qif.resp_found !== ef || qif.resp_combination !== ec ||
          qif.resp_count !== en || qif.resp_min_combination !== em) begin
        errors++;
        $display("FAIL b2b_%0d k=%b p=%0d c=%0d: got v=%b f=%b c=%0d n=%0d m=%0d, expected 1 %b %0d %0d %0d",
                 i, kd, p, qc, qif.resp_valid, qif.resp_found, qif.resp_combination,
                 qif.resp_count, qif.resp_min_combination, ef, ec, en, em);
      end
    end
    qif.query_valid = 1'b0;
    tick;
  endtask

  task automatic test_random_builds;
    int busy, nb; logic done, ok, f, ef; logic [CW-1:0] c, mn, ec, em; logic [CNTW-1:0] n, en;
    logic [L-1:0] p; logic [CW-1:0] qc; logic kd;
    for (int r = 0; r < 4; r++) begin
      set_masks(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      nb = (r == 0) ? 13 : int'($urandom_range(0, 15));
      do_build(nb, busy, done);
      checks++;
      if (!done || busy != 2 * model_n + 1) begin
        errors++;
        $display("FAIL rand_build%0d N=%0d: got busy=%0d done=%b, expected %0d 1", r, nb, busy, done, 2 * model_n + 1);
      end
      for (int i = 0; i < 8; i++) begin
        kd = 1'($urandom_range(0, 1));
        p  = 4'($urandom_range(0, 15));
        qc = 4'($urandom_range(0, 15));
        do_query(kd, p, qc, ok, f, c, n, mn);
        model_query(kd, p, qc, ef, ec, en, em);
        checks++;
        if (ok !== 1'b1 || f !== ef || c !== ec || n !== en || mn !== em) begin
          errors++;
          $display("FAIL rand%0d_q%0d k=%b p=%0d c=%0d: got v=%b f=%b c=%0d n=%0d m=%0d, expected 1 %b %0d %0d %0d",
                   r, i, kd, p, qc, ok, f, c, n, mn, ef, ec, en, em);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_plan_build;
    test_small_and_restart;
    test_reset_mid_build;
    test_back_to_back;
    test_random_builds;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
